// File: rtl/mul_hilo_seq.sv
// ============================================================================
//  Module      : mul_hilo_seq
//  Description : Sequencer and HI/LO register pair for a combinational 32x32
//                signed multiplier. Captures operands on start, waits a fixed
//                number of settle cycles, then latches the 64-bit product.
//                Also supports direct HI/LO loads from the datapath bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_hilo_seq #(
    parameter int MUL_CYCLES = 2      // settle cycles, legal range 1..15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic        busy,
    output logic        done,
    output logic        wr_conflict
);

    // Counter reload: the latch happens on the edge where the count is zero,
    // so loading MUL_CYCLES-1 yields exactly MUL_CYCLES edges after capture.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q_r, hi_d;
    logic [31:0] lo_q_r, lo_d;
    logic        done_q, done_d;
    logic        conflict_q, conflict_d;

    // Next-state logic: sequencing, operand capture, product and direct loads
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        hi_d       = hi_q_r;
        lo_d       = lo_q_r;
        done_d     = 1'b0;
        conflict_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Direct loads apply in IDLE even alongside start; a product
                // arriving later simply overwrites them.
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Writes cannot be honoured mid-multiply; drop and flag them.
                if (hi_wr || lo_wr) conflict_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous clear taking priority over everything
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            hi_q_r     <= 32'd0;
            lo_q_r     <= 32'd0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            hi_q_r     <= hi_d;
            lo_q_r     <= lo_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign hi_q        = hi_q_r;
    assign lo_q        = lo_q_r;
    assign busy        = (state_q == S_SETTLE);
    assign done        = done_q;
    assign wr_conflict = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_hilo_seq.sv
// ============================================================================
//  Module      : tb_mul_hilo_seq
//  Description : Directed self-checking bench for mul_hilo_seq. A behavioural
//                signed multiplier stands in for the combinational Booth unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_hilo_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;
    logic        done;
    logic        wr_conflict;

    int n_checks;
    int n_pass;

    mul_hilo_seq #(.MUL_CYCLES(2)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_hi      (mul_hi),
        .mul_lo      (mul_lo),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wr_data     (wr_data),
        .hi_q        (hi_q),
        .lo_q        (lo_q),
        .busy        (busy),
        .done        (done),
        .wr_conflict (wr_conflict)
    );

    // Behavioural stand-in for the combinational signed multiplier
    logic signed [63:0] w_prod;
    assign w_prod = $signed(mul_a) * $signed(mul_b);
    assign mul_hi = w_prod[63:32];
    assign mul_lo = w_prod[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge; inputs and samples both happen 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;

        // Reset held two cycles
        step(); step();
        clr = 1'b0;
        chk("rst_mul_a", 64'(mul_a), 64'h0);
        chk("rst_mul_b", 64'(mul_b), 64'h0);
        chk("rst_hilo", {hi_q, lo_q}, 64'h0);
        chk("rst_flags", {61'd0, busy, done, wr_conflict}, 64'h0);

        // 7 * -3 = -21
        op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
        step();                                   // E0
        start = 1'b0; op_a = 32'd99; op_b = 32'd99;
        chk("m1_busy0", 64'(busy), 64'd1);
        chk("m1_ops", {mul_a, mul_b}, 64'h0000_0007_FFFF_FFFD);
        step();                                   // E1
        chk("m1_busy1", {62'd0, busy, done}, 64'b10);
        chk("m1_hold", {hi_q, lo_q}, 64'h0);
        step();                                   // E2: product latched
        chk("m1_done", {62'd0, busy, done}, 64'b01);
        chk("m1_prod", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFEB);
        step();
        chk("m1_done_off", 64'(done), 64'd0);

        // 0x80000000^2 then back-to-back (-1)*(-1) started while done is high
        op_a = 32'h8000_0000; op_b = 32'h8000_0000; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        chk("m2_done", 64'(done), 64'd1);
        chk("m2_prod", {hi_q, lo_q}, 64'h4000_0000_0000_0000);
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        step(); start = 1'b0;
        chk("m3_b2b_busy", 64'(busy), 64'd1);
        chk("m3_ops", {mul_a, mul_b}, 64'hFFFF_FFFF_FFFF_FFFF);
        step(); step();
        chk("m3_prod", {hi_q, lo_q}, 64'h0000_0000_0000_0001);

        // Start during SETTLE is ignored
        op_a = 32'd5; op_b = 32'd6; start = 1'b1;
        step();
        op_a = 32'd100; op_b = 32'd200;           // start still high while busy
        step(); start = 1'b0;
        chk("m4_ops_held", {mul_a, mul_b}, 64'h0000_0005_0000_0006);
        step();
        chk("m4_prod", {hi_q, lo_q}, 64'd30);
        step();
        chk("m4_no_restart", 64'(busy), 64'd0);

        // Direct writes in IDLE
        hi_wr = 1'b1; wr_data = 32'hCAFE_BABE;
        step(); hi_wr = 1'b0;
        chk("wr_hi", {hi_q, lo_q}, 64'hCAFE_BABE_0000_001E);
        lo_wr = 1'b1; wr_data = 32'h1234_5678;
        step(); lo_wr = 1'b0;
        chk("wr_lo", {hi_q, lo_q}, 64'hCAFE_BABE_1234_5678);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hA5A5_A5A5;
        step(); hi_wr = 1'b0; lo_wr = 1'b0;
        chk("wr_both", {hi_q, lo_q}, 64'hA5A5_A5A5_A5A5_A5A5);

        // start + hi_wr same cycle, then a write while busy
        op_a = 32'd2; op_b = 32'd3; start = 1'b1; hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        step(); start = 1'b0; hi_wr = 1'b0;
        chk("wr_with_start", {hi_q, lo_q}, 64'hDEAD_BEEF_A5A5_A5A5);
        lo_wr = 1'b1; wr_data = 32'h1234_5678;
        step(); lo_wr = 1'b0;
        chk("wr_busy_dropped", {hi_q, lo_q}, 64'hDEAD_BEEF_A5A5_A5A5);
        chk("wr_conflict_on", 64'(wr_conflict), 64'd1);
        step();
        chk("wr_conflict_off", 64'(wr_conflict), 64'd0);
        chk("m5_prod", {hi_q, lo_q}, 64'd6);

        // clr one cycle before the product latch
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        step(); start = 1'b0;
        step();
        clr = 1'b1;
        step(); clr = 1'b0;
        chk("clr_hilo", {hi_q, lo_q}, 64'h0);
        chk("clr_ops", {mul_a, mul_b}, 64'h0);
        chk("clr_flags", {61'd0, busy, done, wr_conflict}, 64'h0);
        op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        step(); start = 1'b0;
        chk("post_clr_busy", {62'd0, busy, done}, 64'b10);
        step(); step();
        chk("post_clr_done", 64'(done), 64'd1);
        chk("post_clr_prod", {hi_q, lo_q}, 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
